// File: rtl/zigzag_serializer.sv
// Two-slot MCU buffer feeding a zigzag-order coefficient serializer, with an
// optional JPEG run-length mode that emits run/ZRL/EOB beats for Huffman coding.
module zigzag_serializer #(
    parameter int unsigned NUM_CH        = 3,
    parameter int unsigned QUAN_BITWIDTH = 12,
    parameter bit          SKIP_ZEROS    = 1'b0,
    parameter int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                           clk,
    input  logic                                           n_rst,
    input  logic                                           i_valid,
    output logic                                           o_ready,
    input  logic [NUM_CH-1:0][7:0][7:0][QUAN_BITWIDTH-1:0] i_quan,
    input  logic                                           i_last,
    output logic                                           o_valid,
    input  logic                                           i_ready,
    output logic [QUAN_BITWIDTH-1:0]                       o_coef,
    output logic [CH_W-1:0]                                o_ch,
    output logic [5:0]                                     o_idx,
    output logic [3:0]                                     o_run,
    output logic                                           o_eob,
    output logic                                           o_last
);

    localparam int unsigned QW      = QUAN_BITWIDTH;
    localparam int unsigned LAST_CH = NUM_CH - 1;

    typedef logic [NUM_CH-1:0][7:0][7:0][QW-1:0] mcu_t;
    typedef logic [NUM_CH-1:0][5:0]              lnz_t;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EOB} state_t;

    // Raster position (row*8+col) of each zigzag index
    localparam logic [5:0] ZZ_RASTER [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    mcu_t            slot_q [2];
    lnz_t            lnz_q  [2];
    logic [1:0]      full_q, full_d;
    logic [1:0]      slast_q;
    logic            wr_q;
    logic            rd_q, rd_d;
    logic            ready_q, ready_d;

    state_t          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [5:0]      k_q, k_d;
    logic [3:0]      run_q, run_d;

    logic            valid_q;
    logic [QW-1:0]   coef_q;
    logic [CH_W-1:0] och_q;
    logic [5:0]      idx_q;
    logic [3:0]      orun_q;
    logic            eob_q, last_q;
    logic            fin_q, fslot_q;

    logic            cap, byp, cur_full, nxt_full, cur_last, out_free, ch_last;
    mcu_t            cur_mcu;
    lnz_t            cap_lnz, cur_lnz_all;
    logic [5:0]      lnz, pos;
    logic [QW-1:0]   coef;
    logic            emit, end_ch, beat_fin;
    logic [QW-1:0]   b_coef;
    logic [5:0]      b_idx;
    logic [3:0]      b_run;

    // Highest nonzero AC zigzag index per channel of the incoming MCU
    always_comb begin
        cap_lnz = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 1; k < 64; k++) begin
                if (i_quan[c][ZZ_RASTER[k][5:3]][ZZ_RASTER[k][2:0]] != '0) begin
                    cap_lnz[c] = 6'(k);
                end
            end
        end
    end

    // An MCU captured into the empty read slot is scanned straight from the input
    assign cap         = i_valid && ready_q;
    assign byp         = cap && (wr_q == rd_q) && !full_q[rd_q];
    assign cur_full    = full_q[rd_q] || byp;
    assign nxt_full    = full_q[~rd_q] || (cap && (wr_q != rd_q));
    assign cur_mcu     = byp ? i_quan  : slot_q[rd_q];
    assign cur_lnz_all = byp ? cap_lnz : lnz_q[rd_q];
    assign cur_last    = byp ? i_last  : slast_q[rd_q];
    assign lnz         = cur_lnz_all[ch_q];
    assign pos         = ZZ_RASTER[k_q];
    assign coef        = cur_mcu[ch_q][pos[5:3]][pos[2:0]];
    assign out_free    = !valid_q || i_ready;
    assign ch_last     = (ch_q == CH_W'(LAST_CH));

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        ch_d    = ch_q;
        k_d     = k_q;
        run_d   = run_q;
        emit    = 1'b0;
        end_ch  = 1'b0;
        b_coef  = '0;
        b_idx   = k_q;
        b_run   = '0;
        if (out_free) begin
            case (state_q)
                S_IDLE, S_SCAN: begin
                    if (state_q == S_SCAN || cur_full) begin
                        state_d = S_SCAN;
                        if (SKIP_ZEROS == 1'b0) begin
                            emit   = 1'b1;
                            b_coef = coef;
                            if (k_q == 6'd63) end_ch = 1'b1;
                            else              k_d    = k_q + 6'd1;
                        end else if (k_q == 6'd0) begin
                            emit   = 1'b1;
                            b_coef = coef;
                            if (lnz == 6'd0) state_d = S_EOB;
                            else             k_d     = 6'd1;
                        end else begin
                            // Zeros accumulate silently; the 16th consecutive zero becomes a ZRL
                            if (coef != '0) begin
                                emit   = 1'b1;
                                b_coef = coef;
                                b_run  = run_q;
                                run_d  = 4'd0;
                            end else if (run_q == 4'd15) begin
                                emit   = 1'b1;
                                b_run  = 4'd15;
                                run_d  = 4'd0;
                            end else begin
                                run_d  = run_q + 4'd1;
                            end
                            if (k_q == lnz) begin
                                if (k_q == 6'd63) end_ch  = 1'b1;
                                else              state_d = S_EOB;
                            end else begin
                                k_d = k_q + 6'd1;
                            end
                        end
                    end
                end
                S_EOB: begin
                    emit   = 1'b1;
                    b_idx  = 6'd63;
                    end_ch = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
            if (end_ch) begin
                k_d   = 6'd0;
                run_d = 4'd0;
                if (ch_last) begin
                    ch_d    = '0;
                    rd_d    = ~rd_q;
                    state_d = nxt_full ? S_SCAN : S_IDLE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_SCAN;
                end
            end
        end
    end

    assign beat_fin = end_ch && ch_last;

    // A slot frees when the final beat of its MCU is accepted downstream
    always_comb begin
        full_d = full_q;
        if (valid_q && i_ready && fin_q) full_d[fslot_q] = 1'b0;
        if (cap)                         full_d[wr_q]    = 1'b1;
        ready_d = ~&full_d;
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            slot_q[wr_q] <= i_quan;
            lnz_q[wr_q]  <= cap_lnz;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            full_q  <= '0;
            slast_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ready_q <= 1'b0;
            state_q <= S_IDLE;
            ch_q    <= '0;
            k_q     <= '0;
            run_q   <= '0;
            valid_q <= 1'b0;
            coef_q  <= '0;
            och_q   <= '0;
            idx_q   <= '0;
            orun_q  <= '0;
            eob_q   <= 1'b0;
            last_q  <= 1'b0;
            fin_q   <= 1'b0;
            fslot_q <= 1'b0;
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
            state_q <= state_d;
            rd_q    <= rd_d;
            ch_q    <= ch_d;
            k_q     <= k_d;
            run_q   <= run_d;
            if (cap) begin
                slast_q[wr_q] <= i_last;
                wr_q          <= ~wr_q;
            end
            if (out_free) begin
                valid_q <= emit;
                if (emit) begin
                    coef_q  <= b_coef;
                    och_q   <= ch_q;
                    idx_q   <= b_idx;
                    orun_q  <= b_run;
                    eob_q   <= end_ch;
                    last_q  <= beat_fin && cur_last;
                    fin_q   <= beat_fin;
                    fslot_q <= rd_q;
                end
            end
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_coef  = coef_q;
    assign o_ch    = och_q;
    assign o_idx   = idx_q;
    assign o_run   = orun_q;
    assign o_eob   = eob_q;
    assign o_last  = last_q;

endmodule

// File: tb/tb_zigzag_serializer.sv
// Directed bench: dut_a streams all 64 coefficients, dut_b emits run-length beats.
module tb_zigzag_serializer;

    localparam int unsigned NCH = 3;
    localparam int unsigned QW  = 12;
    localparam int unsigned CW  = 2;

    typedef logic [NCH-1:0][7:0][7:0][QW-1:0] mcu_t;
    typedef logic [25:0] beat_t;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    logic          a_iv, a_ordy, a_il, a_ov, a_ir, a_eob, a_last;
    mcu_t          a_q;
    logic [QW-1:0] a_coef;
    logic [CW-1:0] a_ch;
    logic [5:0]    a_idx;
    logic [3:0]    a_run;

    logic          b_iv, b_ordy, b_il, b_ov, b_ir, b_eob, b_last;
    mcu_t          b_q;
    logic [QW-1:0] b_coef;
    logic [CW-1:0] b_ch;
    logic [5:0]    b_idx;
    logic [3:0]    b_run;

    zigzag_serializer #(.NUM_CH(NCH), .QUAN_BITWIDTH(QW), .SKIP_ZEROS(1'b0)) dut_a (
        .clk(clk), .n_rst(n_rst), .i_valid(a_iv), .o_ready(a_ordy), .i_quan(a_q),
        .i_last(a_il), .o_valid(a_ov), .i_ready(a_ir), .o_coef(a_coef), .o_ch(a_ch),
        .o_idx(a_idx), .o_run(a_run), .o_eob(a_eob), .o_last(a_last)
    );

    zigzag_serializer #(.NUM_CH(NCH), .QUAN_BITWIDTH(QW), .SKIP_ZEROS(1'b1)) dut_b (
        .clk(clk), .n_rst(n_rst), .i_valid(b_iv), .o_ready(b_ordy), .i_quan(b_q),
        .i_last(b_il), .o_valid(b_ov), .i_ready(b_ir), .o_coef(b_coef), .o_ch(b_ch),
        .o_idx(b_idx), .o_run(b_run), .o_eob(b_eob), .o_last(b_last)
    );

    int checks = 0;
    int errors = 0;
    int zz [64];
    beat_t expq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic beat_t vec_a();
        return {a_coef, a_ch, a_idx, a_run, a_eob, a_last};
    endfunction

    function automatic beat_t vec_b();
        return {b_coef, b_ch, b_idx, b_run, b_eob, b_last};
    endfunction

    function automatic beat_t mk(input int c, input int k, input int cf, input int run,
                                 input bit eob, input bit last);
        return {QW'(cf), CW'(c), 6'(k), 4'(run), eob, last};
    endfunction

    // Full-stream beat n: MCU m = n/192 holds 512*m + 100*ch + raster position
    function automatic beat_t exp_a(input int n, input int last_n);
        int m = n / 192;
        int c = (n / 64) % 3;
        int k = n % 64;
        return mk(c, k, 512 * m + 100 * c + zz[k], 0, (k == 63), (n == last_n));
    endfunction

    function automatic mcu_t pat(input int m);
        mcu_t x;
        for (int c = 0; c < NCH; c++)
            for (int p = 0; p < 64; p++)
                x[c][p / 8][p % 8] = QW'(512 * m + 100 * c + p);
        return x;
    endfunction

    task automatic put(inout mcu_t x, input int c, input int k, input int val);
        x[c][zz[k] / 8][zz[k] % 8] = QW'(val);
    endtask

    task automatic drain_a(input int first, input int total, input int last_n,
                           input bit stall, output int cyc);
        int n = first;
        beat_t held = '0;
        bit stalled = 1'b0;
        cyc = 0;
        while (n < total && cyc < 4000) begin
            a_ir = stall ? 1'((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (stalled) chk("stall_hold", 32'(vec_a()), 32'(held));
            stalled = a_ov && !a_ir;
            held = vec_a();
            if (a_ov && a_ir) begin
                chk($sformatf("a_beat%0d", n), 32'(vec_a()), 32'(exp_a(n, last_n)));
                n++;
            end
            cyc++;
            @(negedge clk);
        end
        a_ir = 1'b0;
        chk("a_beat_count", 32'(n), 32'(total));
    endtask

    initial begin
        int zr, zc, n, cyc, stale;
        bit cap3, found;
        mcu_t ma, mb;

        zr = 0; zc = 0;
        for (int k = 0; k < 64; k++) begin
            zz[k] = zr * 8 + zc;
            if (((zr + zc) % 2) == 0) begin
                if (zc == 7)      zr++;
                else if (zr == 0) zc++;
                else begin zr--; zc++; end
            end else begin
                if (zr == 7)      zc++;
                else if (zc == 0) zr++;
                else begin zr++; zc--; end
            end
        end

        a_iv = 0; a_il = 0; a_ir = 0; a_q = '0;
        b_iv = 0; b_il = 0; b_ir = 0; b_q = '0;
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        #10;
        chk("reset_ready_a", 32'(a_ordy), 32'(0));
        chk("reset_outs_a", 32'({a_ov, vec_a()}), 32'(0));
        chk("reset_outs_b", 32'({b_ordy, b_ov, vec_b()}), 32'(0));

        @(negedge clk) n_rst = 1'b1;
        #1 chk("ready_low_at_release", 32'(a_ordy), 32'(0));
        @(negedge clk);
        chk("ready_after_reset", 32'(a_ordy), 32'(1));

        // Full stream, free-running downstream
        a_q = pat(0); a_il = 1'b0; a_iv = 1'b1; a_ir = 1'b1;
        @(negedge clk) a_iv = 1'b0;
        chk("latency1_valid", 32'(a_ov), 32'(1));
        drain_a(0, 192, -1, 1'b0, cyc);
        chk("no_bubbles", 32'(cyc), 32'(192));
        chk("ready_after_drain", 32'(a_ordy), 32'(1));
        chk("idle_after_drain", 32'(a_ov), 32'(0));

        // Same stream with downstream toggling 1,0,0,1 and i_last set
        a_q = pat(0); a_il = 1'b1; a_iv = 1'b1;
        @(negedge clk) a_iv = 1'b0;
        drain_a(0, 192, 191, 1'b1, cyc);

        // Three MCUs offered back-to-back while downstream is stalled
        a_q = pat(0); a_il = 1'b0; a_iv = 1'b1; a_ir = 1'b0;
        @(negedge clk);
        chk("ready_one_slot", 32'(a_ordy), 32'(1));
        a_q = pat(1);
        @(negedge clk);
        chk("ready_full", 32'(a_ordy), 32'(0));
        a_q = pat(2); a_il = 1'b1;
        repeat (3) @(negedge clk);
        chk("still_full", 32'(a_ordy), 32'(0));
        chk("held_first_beat", 32'(vec_a()), 32'(exp_a(0, 575)));
        n = 0; cyc = 0; cap3 = 1'b0; a_ir = 1'b1;
        while (n < 576 && cyc < 4000) begin
            if (n == 191) chk("ready_before_free", 32'(a_ordy), 32'(0));
            if (n == 192 && a_iv) chk("ready_after_free", 32'(a_ordy), 32'(1));
            if (a_iv && a_ordy) cap3 = 1'b1;
            if (a_ov) begin
                chk($sformatf("b2b_beat%0d", n), 32'(vec_a()), 32'(exp_a(n, 575)));
                n++;
            end
            cyc++;
            @(negedge clk);
            if (cap3) a_iv = 1'b0;
        end
        a_ir = 1'b0;
        chk("b2b_count", 32'(n), 32'(576));
        chk("b2b_cycles", 32'(cyc), 32'(576));

        // Run-length mode: two MCUs with hand-derived beat lists
        ma = '0; mb = '0;
        put(ma, 0, 0, -5); put(ma, 0, 3, 7);
        put(ma, 1, 0, 1);  put(ma, 1, 40, 2);
        put(mb, 0, 63, 9); put(mb, 2, 1, -1);
        expq.push_back(mk(0, 0, -5, 0, 0, 0));
        expq.push_back(mk(0, 3, 7, 2, 0, 0));
        expq.push_back(mk(0, 63, 0, 0, 1, 0));
        expq.push_back(mk(1, 0, 1, 0, 0, 0));
        expq.push_back(mk(1, 16, 0, 15, 0, 0));
        expq.push_back(mk(1, 32, 0, 15, 0, 0));
        expq.push_back(mk(1, 40, 2, 7, 0, 0));
        expq.push_back(mk(1, 63, 0, 0, 1, 0));
        expq.push_back(mk(2, 0, 0, 0, 0, 0));
        expq.push_back(mk(2, 63, 0, 0, 1, 0));
        expq.push_back(mk(0, 0, 0, 0, 0, 0));
        expq.push_back(mk(0, 16, 0, 15, 0, 0));
        expq.push_back(mk(0, 32, 0, 15, 0, 0));
        expq.push_back(mk(0, 48, 0, 15, 0, 0));
        expq.push_back(mk(0, 63, 9, 14, 1, 0));
        expq.push_back(mk(1, 0, 0, 0, 0, 0));
        expq.push_back(mk(1, 63, 0, 0, 1, 0));
        expq.push_back(mk(2, 0, 0, 0, 0, 0));
        expq.push_back(mk(2, 1, -1, 0, 0, 0));
        expq.push_back(mk(2, 63, 0, 0, 1, 1));
        b_q = ma; b_il = 1'b0; b_iv = 1'b1; b_ir = 1'b1;
        @(negedge clk);
        chk("rl_latency1", 32'(b_ov), 32'(1));
        b_q = mb; b_il = 1'b1;
        n = 0; cyc = 0;
        while (n < expq.size() && cyc < 1000) begin
            if (b_ov) begin
                chk($sformatf("rl_beat%0d", n), 32'(vec_b()), 32'(expq[n]));
                n++;
            end
            cyc++;
            @(negedge clk);
            if (cyc == 1) b_iv = 1'b0;
        end
        chk("rl_count", 32'(n), 32'(expq.size()));
        repeat (2) @(negedge clk);
        chk("rl_idle", 32'({b_ov, b_ordy}), 32'(1));

        // Reset in the middle of channel 1
        a_q = pat(0); a_il = 1'b0; a_iv = 1'b1; a_ir = 1'b1;
        @(negedge clk) a_iv = 1'b0;
        found = 1'b0; cyc = 0;
        while (!found && cyc < 500) begin
            if (a_ov && a_ch == 2'd1 && a_idx == 6'd20) found = 1'b1;
            else begin cyc++; @(negedge clk); end
        end
        chk("reached_ch1_k20", 32'(found), 32'(1));
        n_rst = 1'b0;
        #1;
        chk("midreset_outs", 32'({a_ov, a_ordy, vec_a()}), 32'(0));
        @(negedge clk) n_rst = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", 32'(a_ordy), 32'(1));
        stale = 0;
        repeat (5) begin
            if (a_ov) stale++;
            @(negedge clk);
        end
        chk("no_stale_beats", 32'(stale), 32'(0));
        a_q = pat(1); a_il = 1'b1; a_iv = 1'b1;
        @(negedge clk) a_iv = 1'b0;
        drain_a(192, 384, 383, 1'b0, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zigzag_serializer.md
Name: zigzag_serializer

Overview:
- Successor to the parallel zigzag stage.
- Accepts one MCU of NUM_CH quantised 8x8 blocks in raster order over a valid/ready handshake, holding up to two MCUs (ping-pong).
- Emits coefficients serially, one beat per handshake, in zigzag order, channel 0 first.
- Optional zero-skip mode produces JPEG run/size-ready beats (run, ZRL, EOB) for the Huffman stage that follows.

Parameters:
- NUM_CH, 3: channels per MCU (Y,U,V = 3). Must be at least 1.
- QUAN_BITWIDTH, 12: width of each signed coefficient.
- SKIP_ZEROS, 0: 0 emits all 64 coefficients per block; 1 emits run-length beats.
- CH_W, max(1,$clog2(NUM_CH)): width of o_ch (derived).

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous assert, active-low.
- i_valid  in  1  input MCU valid.
- o_ready  out  1  input MCU can be accepted.
- i_quan  in  NUM_CH*64*QUAN_BITWIDTH  packed [NUM_CH-1:0][7:0][7:0][QUAN_BITWIDTH-1:0]; [c][row][col], row-major.
- i_last  in  1  MCU is last of frame.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts beat.
- o_coef  out  QUAN_BITWIDTH  coefficient value.
- o_ch  out  CH_W  channel of beat.
- o_idx  out  6  zigzag index of beat.
- o_run  out  4  zeros preceding o_coef (SKIP_ZEROS=1; always 0 otherwise).
- o_eob  out  1  final beat of a channel block.
- o_last  out  1  final beat of final channel of an MCU captured with i_last=1.

Behaviour:
- Reset (n_rst low, async):
  - o_valid=0, o_ready=0, o_coef=0, o_ch=0, o_idx=0, o_run=0, o_eob=0, o_last=0.
  - Both slots empty; scan state IDLE.
  - o_ready rises on the first clk edge after n_rst deasserts.
  - Reset mid-operation discards all held MCUs and any in-flight beat.
- Capture:
  - On i_valid && o_ready the MCU and i_last are written into the free slot. For each channel, last_nz = highest zigzag index k≥1 with a nonzero coefficient, or 0 if none.
  - o_ready = (slots occupied < 2).
  - A slot frees on handshake of its last beat; o_ready reflects that on the next cycle. No same-cycle pass-through.
  - With both slots empty, the first beat is valid the cycle after capture (latency 1).
- Zigzag order: element (r,c) maps to standard JPEG index; row 0 = 0,1,5,6,14,15,27,28 … row 7 = 35,36,48,49,57,58,62,63.
- Scan FSM states: IDLE, SCAN, EOB.
  - IDLE -> SCAN when a slot is full.
  - SCAN advances k 0..63 for channel ch, at most one index per cycle, and advances only on a handshake or a skipped index.
  - After a channel ends, ch increments. After ch=NUM_CH-1 the slot is released and the FSM goes to the other slot if full, else IDLE. No bubble when back-to-back.
- SKIP_ZEROS=0:
  - 64 beats per channel, o_run=0.
  - o_eob=1 at k=63.
  - o_last = slot i_last && ch=NUM_CH-1 && k=63.
- SKIP_ZEROS=1:
  - k=0 (DC) is always emitted, run=0.
  - For 1≤k≤last_nz:
    - A nonzero coefficient emits with o_run=zero count, then the count clears.
    - A zero coefficient increments the count, with o_valid=0 that cycle.
    - If the count reaches 16 before a nonzero, emit a ZRL beat: coef 0, o_run=15, o_idx=k. The count then clears.
  - If last_nz=63, the k=63 beat carries o_eob=1 (no EOB beat).
  - Otherwise, after last_nz go to EOB state and emit one beat: coef 0, run 0, o_idx=63, o_eob=1. Indices above last_nz are not scanned.
  - o_last accompanies the final o_eob beat of the final channel.
- Backpressure: while o_valid && !i_ready, all outputs hold stable; capture continues independently.
- i_valid while o_ready=0: ignored, no capture; the source must hold.

Test Plan:
- SKIP_ZEROS=0, NUM_CH=3, block c has value 100*c + raster position, i_ready=1.
  -> 192 beats; channel 0 beat 2 = 8, beat 3 = 16, beat 63 = 63 with o_eob=1; o_ch steps 0,1,2.
  -> Latency 1 from capture.
- Same stimulus, i_ready toggling 1,0,0,1 repeatedly.
  -> Identical beat sequence; outputs stable during stalls.
- SKIP_ZEROS=1, block DC=-5, zigzag k=3 = 7, all else 0.
  -> Beats: (idx0, -5, run0), (idx3, 7, run2), EOB (idx63, 0, run0, eob).
- SKIP_ZEROS=1, only k=0=1 and k=40=2.
  -> DC; ZRL (run15, idx16); ZRL (run15, idx32); (idx40, 2, run7); EOB.
  -> All-zero block gives DC 0 then EOB. k=63 nonzero gives its beat with o_eob=1 and no EOB beat.
- Three MCUs offered back-to-back with i_ready=0 held.
  -> Two captured, o_ready=0, third held.
  -> After the first MCU drains, o_ready=1 the next cycle; the third MCU with i_last=1 sets o_last only on its final beat.
- Assert n_rst mid-MCU at channel 1, k=20.
  -> Outputs reset immediately; after release, o_ready=1 next edge; no stale beats emitted.
